multi_scorekeeper: RTL and testbench

MULTI_SCOREKEEPER -- requirements
Module: multi_scorekeeper

---
 rtl/multi_scorekeeper.sv | 199 +++++++++++++++++++
 tb/tb_multi_scorekeeper.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_scorekeeper.sv
// Multi-player snake scorekeeper: per-player apple crediting, BCD scores, lengths,
// best score, current leader and a 7-segment view of one selected player's score.
module multi_scorekeeper #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned COORD_W     = 7,
  parameter int unsigned NUM_DIGITS  = 2,
  parameter int unsigned INIT_LEN    = 3,
  parameter int unsigned LEN_W       = 7,
  localparam int unsigned SelW       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           gameOver,
  input  logic [NUM_PLAYERS-1:0]         alive,
  input  logic [NUM_PLAYERS*COORD_W-1:0] snakeX,
  input  logic [NUM_PLAYERS*COORD_W-1:0] snakeY,
  input  logic [COORD_W-1:0]             appleX,
  input  logic [COORD_W-1:0]             appleY,
  input  logic [SelW-1:0]                dispSel,
  output logic [NUM_PLAYERS*LEN_W-1:0]   snakelength,
  output logic [NUM_PLAYERS-1:0]         eaten,
  output logic [NUM_DIGITS*7-1:0]        HEX,
  output logic [NUM_DIGITS*4-1:0]        highScore,
  output logic [SelW-1:0]                leader
);

  localparam int unsigned ScoreW = NUM_DIGITS * 4;

  typedef logic [ScoreW-1:0] score_t;
  typedef logic [LEN_W-1:0]  len_t;
  typedef enum logic {StPlay, StStop} state_e;

  localparam score_t ScoreMax = {NUM_DIGITS{4'h9}};
  localparam len_t   LenMax   = '1;
  localparam len_t   LenInit  = LEN_W'(INIT_LEN);

  state_e                  state_q [NUM_PLAYERS];
  state_e                  state_d [NUM_PLAYERS];
  score_t                  score_q [NUM_PLAYERS];
  score_t                  score_d [NUM_PLAYERS];
  len_t                    len_q   [NUM_PLAYERS];
  len_t                    len_d   [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]  hit;
  logic [NUM_PLAYERS-1:0]  hit_q;
  logic [NUM_PLAYERS-1:0]  credit;
  logic [NUM_PLAYERS-1:0]  eaten_q;
  score_t                  high_q, high_d;
  logic [SelW-1:0]         leader_q, leader_d;
  logic [NUM_DIGITS*7-1:0] hex_q, hex_d;

  function automatic score_t bcd_inc(input score_t v);
    score_t r;
    logic   carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (carry) begin
        if (v[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Active-low segments, gfedcba order.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] s;
    case (digit)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      hit[i] = (snakeX[i*COORD_W +: COORD_W] == appleX) &&
               (snakeY[i*COORD_W +: COORD_W] == appleY);
    end
  end

  // Only the lowest-indexed eligible rising hit takes the apple.
  always_comb begin
    logic taken;
    credit = '0;
    taken  = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (hit[i] && !hit_q[i] && state_q[i] == StPlay && !gameOver && alive[i] && !taken) begin
        credit[i] = 1'b1;
        taken     = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      state_d[i] = state_q[i];
      score_d[i] = score_q[i];
      len_d[i]   = len_q[i];
      if (state_q[i] == StPlay && (gameOver || !alive[i])) begin
        state_d[i] = StStop;
      end
      if (credit[i]) begin
        if (score_q[i] != ScoreMax) begin
          score_d[i] = bcd_inc(score_q[i]);
        end
        if (len_q[i] != LenMax) begin
          len_d[i] = len_q[i] + len_t'(1);
        end
      end
    end
  end

  // Packed BCD orders the same as binary, so plain magnitude compares work.
  always_comb begin
    score_t best;
    best     = score_q[0];
    leader_d = '0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (score_q[i] > best) begin
        best     = score_q[i];
        leader_d = SelW'(i);
      end
    end
    high_d = (best > high_q) ? best : high_q;
  end

  always_comb begin
    score_t sel_score;
    logic   sel_ok;
    sel_score = '0;
    sel_ok    = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (dispSel == SelW'(i)) begin
        sel_score = score_q[i];
        sel_ok    = 1'b1;
      end
    end
    hex_d = '1;
    if (sel_ok) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        hex_d[d*7 +: 7] = seg7(sel_score[d*4 +: 4]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        state_q[i] <= StPlay;
        score_q[i] <= '0;
        len_q[i]   <= LenInit;
      end
      hit_q    <= '0;
      eaten_q  <= '0;
      high_q   <= '0;
      leader_q <= '0;
      hex_q    <= {NUM_DIGITS{7'b1000000}};
    end else begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        state_q[i] <= state_d[i];
        score_q[i] <= score_d[i];
        len_q[i]   <= len_d[i];
      end
      hit_q    <= hit;
      eaten_q  <= credit;
      high_q   <= high_d;
      leader_q <= leader_d;
      hex_q    <= hex_d;
    end
  end

  always_comb begin
    snakelength = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      snakelength[i*LEN_W +: LEN_W] = len_q[i];
    end
  end

  assign eaten     = eaten_q;
  assign HEX       = hex_q;
  assign highScore = high_q;
  assign leader    = leader_q;

endmodule

// File: tb/tb_multi_scorekeeper.sv
// Directed bench for multi_scorekeeper at default parameters (2 players, 2 digits).
module tb_multi_scorekeeper;

  logic        clk = 1'b0;
  logic        reset;
  logic        gameOver;
  logic [1:0]  alive;
  logic [13:0] snakeX, snakeY;
  logic [6:0]  appleX, appleY;
  logic        dispSel;
  logic [13:0] snakelength;
  logic [1:0]  eaten;
  logic [13:0] HEX;
  logic [7:0]  highScore;
  logic        leader;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [6:0] S0 = 7'h40;
  localparam logic [6:0] S1 = 7'h79;
  localparam logic [6:0] S3 = 7'h30;
  localparam logic [6:0] S9 = 7'h10;

  always #5 clk = ~clk;

  multi_scorekeeper dut (
    .clk         (clk),
    .reset       (reset),
    .gameOver    (gameOver),
    .alive       (alive),
    .snakeX      (snakeX),
    .snakeY      (snakeY),
    .appleX      (appleX),
    .appleY      (appleY),
    .dispSel     (dispSel),
    .snakelength (snakelength),
    .eaten       (eaten),
    .HEX         (HEX),
    .highScore   (highScore),
    .leader      (leader)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input int p, input logic [6:0] x, input logic [6:0] y);
    snakeX[p*7 +: 7] = x;
    snakeY[p*7 +: 7] = y;
  endtask

  task automatic home;
    set_head(0, 7'd0, 7'd0);
    set_head(1, 7'd10, 7'd10);
  endtask

  task automatic do_reset;
    reset    = 1'b0;
    gameOver = 1'b0;
    alive    = 2'b11;
    dispSel  = 1'b0;
    home();
    step();
    step();
    reset = 1'b1;
  endtask

  // Head onto the apple for one cycle, then back home for one cycle.
  task automatic credit(input int p);
    set_head(p, 7'd5, 7'd5);
    step();
    home();
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests++;
    if (snakelength !== {7'd3, 7'd3}) begin
      n_fail++; $display("FAIL %s len: got %h want %h", tag, snakelength, {7'd3, 7'd3});
    end
    n_tests++;
    if (eaten !== 2'b00) begin
      n_fail++; $display("FAIL %s eaten: got %b want 00", tag, eaten);
    end
    n_tests++;
    if (highScore !== 8'h00) begin
      n_fail++; $display("FAIL %s highScore: got %h want 00", tag, highScore);
    end
    n_tests++;
    if (leader !== 1'b0) begin
      n_fail++; $display("FAIL %s leader: got %b want 0", tag, leader);
    end
    n_tests++;
    if (HEX !== {S0, S0}) begin
      n_fail++; $display("FAIL %s HEX: got %h want %h", tag, HEX, {S0, S0});
    end
  endtask

  task automatic test_reset;
    do_reset();
    check_reset_outputs("reset");
  endtask

  task automatic test_reset_midgame;
    do_reset();
    set_head(0, 7'd5, 7'd5);
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    n_tests++;
    if (eaten !== 2'b01) begin
      n_fail++; $display("FAIL midreset eaten: got %b want 01", eaten);
    end
    n_tests++;
    if (snakelength[6:0] !== 7'd4) begin
      n_fail++; $display("FAIL midreset len0: got %0d want 4", snakelength[6:0]);
    end
    home();
    step();
  endtask

  task automatic test_single;
    int pulses0;
    int pulses1;
    do_reset();
    pulses0 = 0;
    pulses1 = 0;
    set_head(0, 7'd5, 7'd5);
    for (int c = 0; c < 10; c++) begin
      step();
      if (eaten[0]) pulses0++;
      if (eaten[1]) pulses1++;
    end
    n_tests++;
    if (pulses0 != 1 || pulses1 != 0) begin
      n_fail++; $display("FAIL single pulses: got %0d/%0d want 1/0", pulses0, pulses1);
    end
    n_tests++;
    if (snakelength !== {7'd3, 7'd4}) begin
      n_fail++; $display("FAIL single len: got %h want %h", snakelength, {7'd3, 7'd4});
    end
    n_tests++;
    if (HEX !== {S0, S1}) begin
      n_fail++; $display("FAIL single HEX: got %h want %h", HEX, {S0, S1});
    end
    n_tests++;
    if (highScore !== 8'h01) begin
      n_fail++; $display("FAIL single highScore: got %h want 01", highScore);
    end
    home();
    step();
  endtask

  task automatic test_simultaneous;
    int pulses1;
    do_reset();
    pulses1 = 0;
    set_head(0, 7'd5, 7'd5);
    set_head(1, 7'd5, 7'd5);
    step();
    n_tests++;
    if (eaten !== 2'b01) begin
      n_fail++; $display("FAIL simul eaten: got %b want 01", eaten);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      if (eaten[1]) pulses1++;
    end
    home();
    dispSel = 1'b1;
    step();
    step();
    n_tests++;
    if (pulses1 != 0) begin
      n_fail++; $display("FAIL simul p1 pulses: got %0d want 0", pulses1);
    end
    n_tests++;
    if (HEX !== {S0, S0}) begin
      n_fail++; $display("FAIL simul HEX1: got %h want %h", HEX, {S0, S0});
    end
    n_tests++;
    if (snakelength !== {7'd3, 7'd4}) begin
      n_fail++; $display("FAIL simul len: got %h want %h", snakelength, {7'd3, 7'd4});
    end
  endtask

  task automatic test_saturate;
    do_reset();
    repeat (9) credit(0);
    n_tests++;
    if (HEX !== {S0, S9}) begin
      n_fail++; $display("FAIL sat HEX09: got %h want %h", HEX, {S0, S9});
    end
    credit(0);
    n_tests++;
    if (HEX !== {S1, S0}) begin
      n_fail++; $display("FAIL sat HEX10: got %h want %h", HEX, {S1, S0});
    end
    repeat (89) credit(0);
    n_tests++;
    if (HEX !== {S9, S9}) begin
      n_fail++; $display("FAIL sat HEX99: got %h want %h", HEX, {S9, S9});
    end
    n_tests++;
    if (snakelength[6:0] !== 7'd102) begin
      n_fail++; $display("FAIL sat len99: got %0d want 102", snakelength[6:0]);
    end
    set_head(0, 7'd5, 7'd5);
    step();
    n_tests++;
    if (eaten !== 2'b01) begin
      n_fail++; $display("FAIL sat eaten100: got %b want 01", eaten);
    end
    home();
    step();
    n_tests++;
    if (HEX !== {S9, S9}) begin
      n_fail++; $display("FAIL sat HEX100: got %h want %h", HEX, {S9, S9});
    end
    n_tests++;
    if (snakelength[6:0] !== 7'd103) begin
      n_fail++; $display("FAIL sat len100: got %0d want 103", snakelength[6:0]);
    end
    n_tests++;
    if (highScore !== 8'h99) begin
      n_fail++; $display("FAIL sat highScore: got %h want 99", highScore);
    end
  endtask

  task automatic test_gameover;
    do_reset();
    gameOver = 1'b1;
    set_head(1, 7'd5, 7'd5);
    step();
    n_tests++;
    if (eaten !== 2'b00) begin
      n_fail++; $display("FAIL gover same-cycle eaten: got %b want 00", eaten);
    end
    gameOver = 1'b0;
    home();
    step();
    set_head(0, 7'd5, 7'd5);
    step();
    n_tests++;
    if (eaten !== 2'b00) begin
      n_fail++; $display("FAIL gover later eaten: got %b want 00", eaten);
    end
    home();
    dispSel = 1'b1;
    step();
    step();
    n_tests++;
    if (snakelength !== {7'd3, 7'd3}) begin
      n_fail++; $display("FAIL gover len: got %h want %h", snakelength, {7'd3, 7'd3});
    end
    n_tests++;
    if (HEX !== {S0, S0} || highScore !== 8'h00) begin
      n_fail++; $display("FAIL gover frozen: got HEX %h hs %h want %h hs 00", HEX, highScore,
                         {S0, S0});
    end
  endtask

  task automatic test_dead;
    do_reset();
    alive = 2'b01;
    step();
    set_head(1, 7'd5, 7'd5);
    step();
    n_tests++;
    if (eaten !== 2'b00) begin
      n_fail++; $display("FAIL dead p1 eaten: got %b want 00", eaten);
    end
    home();
    step();
    set_head(0, 7'd5, 7'd5);
    step();
    n_tests++;
    if (eaten !== 2'b01) begin
      n_fail++; $display("FAIL dead p0 eaten: got %b want 01", eaten);
    end
    home();
    step();
    n_tests++;
    if (snakelength !== {7'd3, 7'd4}) begin
      n_fail++; $display("FAIL dead len: got %h want %h", snakelength, {7'd3, 7'd4});
    end
  endtask

  task automatic test_leader;
    do_reset();
    repeat (3) credit(1);
    repeat (2) credit(0);
    n_tests++;
    if (highScore !== 8'h03) begin
      n_fail++; $display("FAIL leader highScore: got %h want 03", highScore);
    end
    n_tests++;
    if (leader !== 1'b1) begin
      n_fail++; $display("FAIL leader idx: got %b want 1", leader);
    end
    dispSel = 1'b1;
    step();
    n_tests++;
    if (HEX !== {S0, S3}) begin
      n_fail++; $display("FAIL leader HEX1: got %h want %h", HEX, {S0, S3});
    end
    n_tests++;
    if (snakelength !== {7'd6, 7'd5}) begin
      n_fail++; $display("FAIL leader len: got %h want %h", snakelength, {7'd6, 7'd5});
    end
    do_reset();
    check_reset_outputs("post-reset");
  endtask

  initial begin
    reset    = 1'b0;
    gameOver = 1'b0;
    alive    = 2'b11;
    dispSel  = 1'b0;
    appleX   = 7'd5;
    appleY   = 7'd5;
    snakeX   = '0;
    snakeY   = '0;
    home();
    test_reset();
    test_reset_midgame();
    test_single();
    test_simultaneous();
    test_saturate();
    test_gameover();
    test_dead();
    test_leader();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
